// File: rtl/mem_access_controller_pkg.sv
// mem_access_controller_pkg: FSM states, access-size encodings and store lane helpers
package mem_access_controller_pkg;
  typedef enum logic [1:0] {IDLE, BUS_REQ, RESPOND} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL} size_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_ILLEGAL || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
  endfunction
  function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] data);
    return size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
  endfunction
endpackage

// File: rtl/mem_access_controller_load_unit.sv
// mem_access_controller_load_unit: LOAD_SIZE/LOAD_UNSIGNED select sign or zero extension of right-justified DATA_IN onto OUTPUT
module mem_access_controller_load_unit
  import mem_access_controller_pkg::*;
(
  input  logic [1:0]  LOAD_SIZE,
  input  logic        LOAD_UNSIGNED,
  input  logic [31:0] DATA_IN,
  output logic [31:0] OUTPUT
);
  always_comb
    OUTPUT = LOAD_SIZE == SZ_BYTE ? {{24{!LOAD_UNSIGNED && DATA_IN[7]}}, DATA_IN[7:0]}
           : LOAD_SIZE == SZ_HALF ? {{16{!LOAD_UNSIGNED && DATA_IN[15]}}, DATA_IN[15:0]}
           : LOAD_SIZE == SZ_WORD ? DATA_IN : '0;
endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences load/store accesses (REQ_* from pipeline, BUS_* valid/ready data bus, RSP_* one-cycle completion)
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERROR,
  output logic        BUS_VALID,
  input  logic        BUS_READY,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ERROR
);
  state_t state, state_n;
  logic [1:0] size, off;
  logic uns, err, accept, bad, expire;
  logic [31:0] cap, ext;
  logic [CNT_WIDTH-1:0] cnt;
  assign REQ_READY = (state == IDLE || state == RESPOND) && !RESET;
  assign accept = REQ_VALID && REQ_READY;
  assign bad = misaligned(REQ_SIZE, REQ_ADDR[1:0]);
  assign expire = TIMEOUT_CYCLES != 0 && cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1) && !BUS_READY;
  mem_access_controller_load_unit u_load (
    .LOAD_SIZE(size),
    .LOAD_UNSIGNED(uns),
    .DATA_IN(cap),
    .OUTPUT(ext)
  );
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = bad ? RESPOND : BUS_REQ;
    else if (state == RESPOND) state_n = IDLE;
    else if (state == BUS_REQ && (BUS_READY || expire)) state_n = RESPOND;
    BUS_VALID = state == BUS_REQ;
    RSP_VALID = state == RESPOND;
    RSP_ERROR = RSP_VALID && err;
    RSP_RDATA = RSP_VALID && !err && !BUS_WE ? ext : '0;
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      {size, uns, off, err, cnt, cap} <= '0;
      {BUS_WE, BUS_ADDR, BUS_WSTRB, BUS_WDATA} <= '0;
    end else if (accept) begin
      size <= REQ_SIZE;
      uns <= REQ_UNSIGNED;
      off <= REQ_ADDR[1:0];
      err <= bad;
      cnt <= '0;
      BUS_WE <= REQ_WRITE;
      BUS_ADDR <= {REQ_ADDR[31:2], 2'b00};
      BUS_WSTRB <= REQ_WRITE ? strobe(REQ_SIZE, REQ_ADDR[1:0]) : 4'b0000;
      BUS_WDATA <= REQ_WRITE ? lanes(REQ_SIZE, REQ_WDATA) : '0;
    end else if (state == BUS_REQ) begin
      if (BUS_READY) begin
        cap <= BUS_RDATA >> {off, 3'b000};
        err <= BUS_ERROR;
      end else begin
        cnt <= cnt + 1'b1;
        err <= expire;
      end
    end
endmodule
